line_read_port: RTL and testbench
=================================

LINE_READ_PORT -- requirements
Module: line_read_port

Interface
REQ-001 The block SHALL have parameter: CNT_W, 16, width of the saturating miss-fill counter.
REQ-002 The block SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: mem_read  input  1  CPU read request; held high until mem_resp.
REQ-005 The block SHALL have port: mem_address  input  16 (lc3b_word)  CPU byte address of the read.
REQ-006 The block SHALL have port: hit  input  1  tag-compare hit for mem_address, valid in the same cycle.
REQ-007 The block SHALL have port: hit_line  input  128 (pmem_bus)  data-array line for mem_address when hit=1.
REQ-008 The block SHALL have port: pmem_rdata  input  128 (pmem_bus)  line returned by physical memory.
REQ-009 The block SHALL have port: pmem_resp  input  1  physical memory read-complete strobe.
REQ-010 The block SHALL have port: mem_rdata  output  16 (lc3b_word)  word returned to CPU.
REQ-011 The block SHALL have port: mem_resp  output  1  one-cycle CPU completion strobe.
REQ-012 The block SHALL have port: pmem_read  output  1  physical memory line-read request.
REQ-013 The block SHALL have port: pmem_address  output  16  line-aligned physical address.
REQ-014 The block SHALL have port: fill_line  output  128 (pmem_bus)  line to write into the data array.
REQ-015 The block SHALL have port: fill_we  output  1  one-cycle data-array write enable for fill_line.
REQ-016 The block SHALL have port: fill_count  output  CNT_W  number of completed line fills, saturating.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, FILL and RESP.
REQ-018 The word offset SHALL be mem_address[3:1] (cache_offset); the extracted word SHALL be line bits [16*offset +: 16], so byte 2k+1 is in bits [16k+8 +: 8].
REQ-019 In IDLE, when mem_read=1 and hit=1, the block SHALL register the word from hit_line at the offset and move to RESP.
REQ-020 In IDLE, when mem_read=1 and hit=0, the block SHALL latch mem_address and move to FILL.
REQ-021 In FILL, pmem_read SHALL be 1 and pmem_address SHALL be {latched_address[15:4], 4'b0000}, both stable until pmem_resp.
REQ-022 In FILL, on pmem_resp=1, the block SHALL:
- capture pmem_rdata into the line buffer driving fill_line;
- pulse fill_we for exactly the next cycle;
- register the word at the latched offset;
- increment fill_count;
- move to RESP.
REQ-023 In RESP, mem_resp SHALL be 1 for exactly one cycle with mem_rdata valid; the next state SHALL be IDLE.
REQ-024 Hit latency SHALL be 1 cycle (request cycle -> mem_resp next cycle); miss latency SHALL be 1 cycle after the pmem_resp cycle.
REQ-025 If mem_read drops during FILL, the fill SHALL still complete: fill_we pulses and fill_count increments, but mem_resp is not asserted and the FSM returns directly to IDLE.
REQ-026 mem_read in RESP SHALL be ignored; a new request is sampled only in IDLE, giving at most one read per 2 cycles.
REQ-027 pmem_resp outside FILL SHALL be ignored.
REQ-028 fill_count SHALL stop at 2^CNT_W-1 and not wrap.
REQ-029 mem_rdata SHALL hold its last value outside RESP; fill_line SHALL hold the last filled line.

Reset
REQ-030 On reset=1, asynchronously:
- state=IDLE;
- mem_resp=0, pmem_read=0, fill_we=0;
- mem_rdata=0, pmem_address=0, fill_line=0, fill_count=0.
REQ-031 Reset mid-FILL SHALL abandon the fill with no fill_we or mem_resp; after reset, operation resumes from IDLE.

Verification
REQ-032 Hit: hit_line word 5 = 16'hBEEF, mem_address=16'h001A, hit=1 -> mem_resp next cycle with mem_rdata=16'hBEEF; pmem_read stays 0.
REQ-033 Miss: mem_address=16'h1236, hit=0, pmem_resp after 4 cycles with word 3 = 16'hCAFE -> pmem_address=16'h1230 stable; fill_we one cycle; mem_resp with 16'hCAFE; fill_count=1.
REQ-034 Abort: mem_read drops during FILL -> fill completes with fill_we=1, fill_count increments, no mem_resp, FSM back in IDLE.
REQ-035 Reset: assert reset during FILL -> outputs immediately at reset values; a following hit request completes normally.
REQ-036 Saturation: with CNT_W=2, perform 5 misses -> fill_count=3.
REQ-037 Offset sweep: offsets 0..7 with line words 16'h0000..16'h7777 -> each word is returned exactly once.

Source files
------------

// File: rtl/line_read_port_if.sv
// Bus bundle for line_read_port: CPU read channel, physical-memory read
// channel and data-array fill channel. The DUT takes the slave view; the
// environment driving CPU/tag/memory stimulus takes the master view.
interface line_read_port_if #(
    parameter int CNT_W = 16
);
    // CPU side
    logic             mem_read;
    logic [15:0]      mem_address;
    logic [15:0]      mem_rdata;
    logic             mem_resp;
    // Tag/data array lookup result
    logic             hit;
    logic [127:0]     hit_line;
    // Physical memory side
    logic             pmem_read;
    logic [15:0]      pmem_address;
    logic [127:0]     pmem_rdata;
    logic             pmem_resp;
    // Data array fill side
    logic [127:0]     fill_line;
    logic             fill_we;
    logic [CNT_W-1:0] fill_count;

    modport master (
        output mem_read, mem_address, hit, hit_line, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_read, pmem_address,
               fill_line, fill_we, fill_count
    );

    modport slave (
        input  mem_read, mem_address, hit, hit_line, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_read, pmem_address,
               fill_line, fill_we, fill_count
    );
endinterface

// File: rtl/line_read_port.sv
// Read port of a direct cache line: serves hits from the data array in one
// cycle, and on a miss fetches the whole line from physical memory, hands it
// to the data array for writing, and returns the requested word to the CPU.
module line_read_port #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    line_read_port_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [15:0]        paddr_q,   paddr_d;   // line-aligned miss address
    logic [2:0]         offset_q,  offset_d;  // word offset of the pending miss
    logic               abort_q,   abort_d;   // CPU withdrew the request mid-fill
    logic [15:0]        rdata_q,   rdata_d;
    logic [127:0]       line_q,    line_d;
    logic               fill_we_q, fill_we_d;
    logic [CNT_W-1:0]   count_q,   count_d;

    // Word k of a line lives in bits [16k +: 16].
    function automatic logic [15:0] word_at(input logic [127:0] line,
                                            input logic [2:0]   offset);
        return line[{offset, 4'b0000} +: 16];
    endfunction

    // Next-state and datapath update for the IDLE/FILL/RESP sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        paddr_d   = paddr_q;
        offset_d  = offset_q;
        abort_d   = abort_q;
        rdata_d   = rdata_q;
        line_d    = line_q;
        fill_we_d = 1'b0;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_read) begin
                    if (bus.hit) begin
                        rdata_d = word_at(bus.hit_line, bus.mem_address[3:1]);
                        state_d = RESP;
                    end else begin
                        paddr_d  = {bus.mem_address[15:4], 4'b0000};
                        offset_d = bus.mem_address[3:1];
                        abort_d  = 1'b0;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                // Once the CPU drops its request the fill still lands in the
                // array, but nobody is waiting for the word any more.
                if (!bus.mem_read) begin
                    abort_d = 1'b1;
                end
                if (bus.pmem_resp) begin
                    line_d    = bus.pmem_rdata;
                    fill_we_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (abort_q || !bus.mem_read) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = word_at(bus.pmem_rdata, offset_q);
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the line buffer is a plain register, not a RAM array, so
            // clearing it on reset is cheap and gives a defined fill_line.
            state_q   <= IDLE;
            paddr_q   <= '0;
            offset_q  <= '0;
            abort_q   <= 1'b0;
            rdata_q   <= '0;
            line_q    <= '0;
            fill_we_q <= 1'b0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            offset_q  <= offset_d;
            abort_q   <= abort_d;
            rdata_q   <= rdata_d;
            line_q    <= line_d;
            fill_we_q <= fill_we_d;
            count_q   <= count_d;
        end
    end

    assign bus.mem_resp     = (state_q == RESP);
    assign bus.pmem_read    = (state_q == FILL);
    assign bus.mem_rdata    = rdata_q;
    assign bus.pmem_address = paddr_q;
    assign bus.fill_line    = line_q;
    assign bus.fill_we      = fill_we_q;
    assign bus.fill_count   = count_q;

endmodule

// File: tb/tb_line_read_port.sv
// Directed bench for line_read_port: hit, miss, abort, reset mid-fill,
// stray pmem_resp, offset sweep, and counter saturation on a CNT_W=2 copy.
module tb_line_read_port;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    line_read_port_if #(.CNT_W(16)) bus  ();
    line_read_port_if #(.CNT_W(2))  bus2 ();

    line_read_port #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    line_read_port #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] one_word(input int k, input logic [15:0] v);
        logic [127:0] l;
        l = '0;
        l[16*k +: 16] = v;
        return l;
    endfunction

    logic [127:0] line_a;
    logic [127:0] sweep_line;

    initial begin
        reset            = 1'b1;
        bus.mem_read     = 1'b0;
        bus.mem_address  = '0;
        bus.hit          = 1'b0;
        bus.hit_line     = '0;
        bus.pmem_rdata   = '0;
        bus.pmem_resp    = 1'b0;
        bus2.mem_read    = 1'b0;
        bus2.mem_address = '0;
        bus2.hit         = 1'b0;
        bus2.hit_line    = '0;
        bus2.pmem_rdata  = '0;
        bus2.pmem_resp   = 1'b0;

        // Reset state
        #2;
        check("rst_mem_resp",  bus.mem_resp,   1'b0);
        check("rst_pmem_read", bus.pmem_read,  1'b0);
        check("rst_fill_we",   bus.fill_we,    1'b0);
        check("rst_rdata",     bus.mem_rdata,  16'h0);
        check("rst_count",     bus.fill_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Hit: word 5 at address 0x001A
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h001A;
        bus.hit         = 1'b1;
        bus.hit_line    = one_word(5, 16'hBEEF);
        @(negedge clk);
        check("hit_resp",      bus.mem_resp,  1'b1);
        check("hit_rdata",     bus.mem_rdata, 16'hBEEF);
        check("hit_pmem_read", bus.pmem_read, 1'b0);
        bus.mem_read = 1'b0;
        bus.hit      = 1'b0;
        @(negedge clk);
        check("hit_resp_once", bus.mem_resp,  1'b0);
        check("hit_hold",      bus.mem_rdata, 16'hBEEF);

        // Miss: 0x1236 -> line 0x1230, word 3, memory answers after 4 cycles
        line_a = one_word(3, 16'hCAFE) | 128'h1;
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h1236;
        bus.hit         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("miss_pmem_read", bus.pmem_read,    1'b1);
            check("miss_pmem_addr", bus.pmem_address, 16'h1230);
            check("miss_no_resp",   bus.mem_resp,     1'b0);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_a;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check("miss_resp",      bus.mem_resp,   1'b1);
        check("miss_rdata",     bus.mem_rdata,  16'hCAFE);
        check("miss_fill_we",   bus.fill_we,    1'b1);
        check("miss_fill_line", bus.fill_line,  line_a);
        check("miss_count",     bus.fill_count, 16'd1);
        bus.mem_read = 1'b0;
        @(negedge clk);
        check("miss_we_once",   bus.fill_we,    1'b0);
        check("miss_resp_once", bus.mem_resp,   1'b0);
        check("miss_idle",      bus.pmem_read,  1'b0);

        // Abort: CPU drops mem_read during FILL
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h2004;
        @(negedge clk);
        check("abort_fill", bus.pmem_read, 1'b1);
        bus.mem_read = 1'b0;
        @(negedge clk);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 128'h5555;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check("abort_fill_we",   bus.fill_we,    1'b1);
        check("abort_count",     bus.fill_count, 16'd2);
        check("abort_no_resp",   bus.mem_resp,   1'b0);
        check("abort_idle",      bus.pmem_read,  1'b0);
        check("abort_fill_line", bus.fill_line,  128'h5555);
        @(negedge clk);
        check("abort_no_resp2",  bus.mem_resp,   1'b0);
        check("abort_we_once",   bus.fill_we,    1'b0);

        // Reset in the middle of a fill
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h4440;
        @(negedge clk);
        check("rfill_pmem_read", bus.pmem_read, 1'b1);
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        #1;
        check("rfill_pmem_read0", bus.pmem_read,    1'b0);
        check("rfill_paddr",      bus.pmem_address, 16'h0);
        check("rfill_count",      bus.fill_count,   16'd0);
        check("rfill_line",       bus.fill_line,    128'h0);
        check("rfill_rdata",      bus.mem_rdata,    16'h0);
        check("rfill_resp",       bus.mem_resp,     1'b0);
        check("rfill_we",         bus.fill_we,      1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Stray pmem_resp in IDLE is ignored
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 128'hFFFF;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check("stray_we",    bus.fill_we,    1'b0);
        check("stray_count", bus.fill_count, 16'd0);
        check("stray_line",  bus.fill_line,  128'h0);

        // Hit after reset completes normally
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0100;
        bus.hit         = 1'b1;
        bus.hit_line    = one_word(0, 16'h1234);
        @(negedge clk);
        check("post_rst_resp",  bus.mem_resp,  1'b1);
        check("post_rst_rdata", bus.mem_rdata, 16'h1234);
        bus.mem_read = 1'b0;
        @(negedge clk);

        // Offset sweep: word k holds k*0x1111
        for (int k = 0; k < 8; k++) begin
            sweep_line[16*k +: 16] = 16'(k * 16'h1111);
        end
        for (int k = 0; k < 8; k++) begin
            bus.mem_read    = 1'b1;
            bus.mem_address = 16'h0300 + 16'(2 * k);
            bus.hit         = 1'b1;
            bus.hit_line    = sweep_line;
            @(negedge clk);
            check("sweep_resp",  bus.mem_resp,  1'b1);
            check("sweep_rdata", bus.mem_rdata, 16'(k * 16'h1111));
            bus.mem_read = 1'b0;
            @(negedge clk);
            check("sweep_once",  bus.mem_resp,  1'b0);
        end
        bus.hit = 1'b0;

        // Saturation: CNT_W=2 copy, five misses
        for (int n = 1; n <= 5; n++) begin
            bus2.mem_read    = 1'b1;
            bus2.mem_address = 16'h0040 + 16'(16 * n);
            bus2.hit         = 1'b0;
            @(negedge clk);
            bus2.pmem_resp  = 1'b1;
            bus2.pmem_rdata = 128'(n);
            @(negedge clk);
            bus2.pmem_resp = 1'b0;
            check("sat_resp", bus2.mem_resp, 1'b1);
            check("sat_count", bus2.fill_count, (n > 3) ? 2'd3 : 2'(n));
            bus2.mem_read = 1'b0;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
